// File: rtl/switch_pkg.sv
// Shared definitions for user push-button input handling: FSM encoding,
// board timing defaults and the registered event payload.
package switch_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_COUNT = 250_000;     // 10 ms at 25 MHz
  localparam int unsigned DEFAULT_LONG_COUNT     = 25_000_000;  // 1 s at 25 MHz
  localparam int unsigned STATE_W                = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } sw_state_e;

  // Debounced level plus the single-cycle event pulses, registered together.
  typedef struct packed {
    logic level;
    logic press;
    logic release_evt;
    logic long_press;
  } sw_evt_t;

endpackage : switch_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin, with a configurable
// reset level so the idle pin value is presented while in reset.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/switch_debouncer.sv
// Push-button debouncer: synchronizes the raw pin, filters bounce with a
// stability counter and emits press / release / long-press pulses.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT,
  parameter int unsigned LONG_COUNT     = DEFAULT_LONG_COUNT,
  parameter bit          ACTIVE_HIGH    = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long_Press
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_COUNT + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_COUNT + 1);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_COUNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_COUNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_COUNT);
  localparam bit                DB_SINGLE = (DEBOUNCE_COUNT == 32'd1);

  logic              pin_sync;
  logic              sample_c;
  sw_state_e         state_d, state_q;
  logic [DB_W-1:0]   db_cnt_d, db_cnt_q;
  logic [HOLD_W-1:0] hold_d, hold_q;
  sw_evt_t           evt_d, evt_q;

  sync_2ff #(
    .RESET_VAL (~ACTIVE_HIGH)
  ) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Reset_n),
    .d     (i_Switch),
    .q     (pin_sync)
  );

  // Internal sample is always 1 = pressed, whatever the pin polarity.
  assign sample_c = ACTIVE_HIGH ? pin_sync : ~pin_sync;

  // The counter holds the number of consecutive qualifying samples already
  // seen, so the current sample is the DEBOUNCE_COUNT-th when it equals DB_LAST.
  always_comb begin
    state_d           = state_q;
    db_cnt_d          = db_cnt_q;
    hold_d            = hold_q;
    evt_d             = '0;
    evt_d.level       = evt_q.level;

    // Hold timer runs while the debounced level is pressed and saturates.
    if ((state_q == ST_PRESSED || state_q == ST_RELEASE_PEND) && hold_q != HOLD_MAX) begin
      hold_d           = hold_q + HOLD_ONE;
      evt_d.long_press = (hold_q == HOLD_LAST);
    end

    case (state_q)
      ST_RELEASED: begin
        if (sample_c) begin
          if (DB_SINGLE) begin
            state_d     = ST_PRESSED;
            db_cnt_d    = '0;
            hold_d      = '0;
            evt_d.level = 1'b1;
            evt_d.press = 1'b1;
          end else begin
            state_d  = ST_PRESS_PEND;
            db_cnt_d = DB_ONE;
          end
        end
      end

      ST_PRESS_PEND: begin
        if (!sample_c) begin
          state_d  = ST_RELEASED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_PRESSED;
          db_cnt_d    = '0;
          hold_d      = '0;
          evt_d.level = 1'b1;
          evt_d.press = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end

      ST_PRESSED: begin
        if (!sample_c) begin
          if (DB_SINGLE) begin
            state_d           = ST_RELEASED;
            db_cnt_d          = '0;
            hold_d            = '0;
            evt_d.level       = 1'b0;
            evt_d.release_evt = 1'b1;
            evt_d.long_press  = 1'b0;
          end else begin
            state_d  = ST_RELEASE_PEND;
            db_cnt_d = DB_ONE;
          end
        end
      end

      ST_RELEASE_PEND: begin
        if (sample_c) begin
          // Rejected release glitch: the hold timer keeps running.
          state_d  = ST_PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d           = ST_RELEASED;
          db_cnt_d          = '0;
          hold_d            = '0;
          evt_d.level       = 1'b0;
          evt_d.release_evt = 1'b1;
          evt_d.long_press  = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end

      default: begin
        state_d  = ST_RELEASED;
        db_cnt_d = '0;
        hold_d   = '0;
        evt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= ST_RELEASED;
      db_cnt_q <= '0;
      hold_q   <= '0;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
      evt_q    <= evt_d;
    end
  end

  assign o_Switch     = evt_q.level;
  assign o_Press      = evt_q.press;
  assign o_Release    = evt_q.release_evt;
  assign o_Long_Press = evt_q.long_press;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: one active-high and one active-low instance
// checked every cycle against a run-length model, plus directed scenarios.
module tb_switch_debouncer;

  localparam int unsigned D = 4;
  localparam int unsigned L = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sw_h  = 1'b1;
  logic sw_l  = 1'b1;

  logic o_sw_h, o_pr_h, o_rl_h, o_lp_h;
  logic o_sw_l, o_pr_l, o_rl_l, o_lp_l;

  int compared = 0;
  int errors   = 0;
  int lp_cnt_h = 0;
  int rl_cnt_h = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.DEBOUNCE_COUNT(D), .LONG_COUNT(L), .ACTIVE_HIGH(1'b1)) dut_h (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Switch(sw_h),
    .o_Switch(o_sw_h), .o_Press(o_pr_h), .o_Release(o_rl_h), .o_Long_Press(o_lp_h)
  );

  switch_debouncer #(.DEBOUNCE_COUNT(D), .LONG_COUNT(L), .ACTIVE_HIGH(1'b0)) dut_l (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Switch(sw_l),
    .o_Switch(o_sw_l), .o_Press(o_pr_l), .o_Release(o_rl_l), .o_Long_Press(o_lp_l)
  );

  // Model: pin seen two edges late; level flips after D consecutive samples
  // disagreeing with it; long press when held for L edges since acceptance.
  bit          dly1 [2];
  bit          dly2 [2];
  bit          lvl  [2];
  int unsigned run  [2];
  int unsigned held [2];
  bit exp_sw [2];
  bit exp_pr [2];
  bit exp_rl [2];
  bit exp_lp [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      dly1[k] = (k == 1);
      dly2[k] = (k == 1);
      lvl[k] = 1'b0; run[k] = 0; held[k] = 0;
      exp_sw[k] = 1'b0; exp_pr[k] = 1'b0; exp_rl[k] = 1'b0; exp_lp[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit pin);
    bit pressed;
    pressed = (k == 0) ? dly2[k] : ~dly2[k];
    dly2[k] = dly1[k];
    dly1[k] = pin;
    exp_pr[k] = 1'b0; exp_rl[k] = 1'b0; exp_lp[k] = 1'b0;
    run[k] = (pressed != lvl[k]) ? run[k] + 1 : 0;
    if (run[k] == D) begin
      lvl[k]  = pressed;
      run[k]  = 0;
      held[k] = 0;
      if (pressed) exp_pr[k] = 1'b1;
      else         exp_rl[k] = 1'b1;
    end else if (lvl[k] && held[k] < L) begin
      held[k]++;
      if (held[k] == L) exp_lp[k] = 1'b1;
    end
    exp_sw[k] = lvl[k];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, sw_h);
      model_step(1, sw_l);
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    chk("h_switch",  o_sw_h, exp_sw[0]);
    chk("h_press",   o_pr_h, exp_pr[0]);
    chk("h_release", o_rl_h, exp_rl[0]);
    chk("h_long",    o_lp_h, exp_lp[0]);
    chk("l_switch",  o_sw_l, exp_sw[1]);
    chk("l_press",   o_pr_l, exp_pr[1]);
    chk("l_release", o_rl_l, exp_rl[1]);
    chk("l_long",    o_lp_l, exp_lp[1]);
    if (o_lp_h) lp_cnt_h++;
    if (o_rl_h) rl_cnt_h++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lp_base;
    int rl_base;
    int dur;

    // Reset with the switch already pressed.
    rst_n = 1'b0; sw_h = 1'b1; sw_l = 1'b1;
    tick(3);
    chk("rst_switch", o_sw_h, 1'b0);
    chk("rst_press",  o_pr_h, 1'b0);
    chk("rst_rel",    o_rl_h, 1'b0);
    chk("rst_long",   o_lp_h, 1'b0);
    rst_n = 1'b1;
    tick(5);
    chk("rst_press_early", o_pr_h, 1'b0);
    tick(1);
    chk("rst_press_edge6", o_pr_h, 1'b1);
    chk("rst_switch_edge6", o_sw_h, 1'b1);
    lp_base = lp_cnt_h;

    // Long press fires 20 edges after o_Press, no repeat through 40.
    tick(1);
    chk("press_one_cycle", o_pr_h, 1'b0);
    tick(18);
    chk("long_early", o_lp_h, 1'b0);
    tick(1);
    chk("long_edge20", o_lp_h, 1'b1);
    tick(20);
    chk_int("long_count", lp_cnt_h - lp_base, 1);

    // Clean release.
    sw_h = 1'b0;
    tick(5);
    chk("rel_early", o_rl_h, 1'b0);
    tick(1);
    chk("rel_edge6", o_rl_h, 1'b1);
    chk("rel_switch", o_sw_h, 1'b0);
    tick(3);

    // Three-cycle glitch is rejected.
    sw_h = 1'b1;
    tick(3);
    sw_h = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_switch", o_sw_h, 1'b0);
      chk("glitch_press",  o_pr_h, 1'b0);
    end

    // Held press still needs the full window.
    sw_h = 1'b1;
    tick(5);
    chk("press2_early", o_pr_h, 1'b0);
    tick(1);
    chk("press2_edge6", o_pr_h, 1'b1);
    rl_base = rl_cnt_h;
    lp_base = lp_cnt_h;

    // Release bounce; the long press still lands mid-bounce.
    tick(9);
    for (int i = 0; i < 5; i++) begin
      sw_h = (i % 2 == 1);
      if (i < 4) tick(2);
    end
    tick(5);
    chk("bounce_rel_early", o_rl_h, 1'b0);
    tick(1);
    chk("bounce_rel_edge6", o_rl_h, 1'b1);
    chk_int("bounce_rel_count", rl_cnt_h - rl_base, 1);
    chk_int("bounce_long_count", lp_cnt_h - lp_base, 1);
    tick(3);

    // Reset mid-press: no release, press recurs after deassert.
    sw_h = 1'b1;
    tick(6);
    chk("press3_edge6", o_pr_h, 1'b1);
    tick(10);
    rl_base = rl_cnt_h;
    rst_n = 1'b0;
    #1;
    chk("async_rst_switch", o_sw_h, 1'b0);
    chk("async_rst_rel",    o_rl_h, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("rerst_press_early", o_pr_h, 1'b0);
    tick(1);
    chk("rerst_press_edge6", o_pr_h, 1'b1);
    chk_int("rerst_no_release", rl_cnt_h - rl_base, 0);
    sw_h = 1'b0;
    tick(8);

    // Active-low instance.
    sw_l = 1'b0;
    tick(5);
    chk("low_press_early", o_pr_l, 1'b0);
    tick(1);
    chk("low_press_edge6", o_pr_l, 1'b1);
    chk("low_switch_on",   o_sw_l, 1'b1);
    sw_l = 1'b1;
    tick(5);
    chk("low_rel_early", o_rl_l, 1'b0);
    tick(1);
    chk("low_rel_edge6", o_rl_l, 1'b1);
    chk("low_switch_off", o_sw_l, 1'b0);

    // Random bouncing on both pins, with one reset pulse mid-way.
    for (int n = 0; n < 250; n++) begin
      sw_h = 1'($urandom_range(0, 1));
      sw_l = 1'($urandom_range(0, 1));
      dur = ($urandom_range(0, 7) == 0) ? int'($urandom_range(22, 30))
                                        : int'($urandom_range(1, 7));
      if (n == 125) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      tick(dur);
    end
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule : tb_switch_debouncer

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-side counterpart to the board's counter-driven LED outputs. It reads a raw, bouncing push-button and produces a clean debounced level plus single-cycle press, release and long-press event pulses.
- Sits directly behind the switch pin. Its outputs feed LED toggling, mode selection and other user-input logic.
- Timing is derived purely from the i_Clock cycle count; the 25 MHz board clock is the nominal target.

Parameters:
- DEBOUNCE_COUNT, 250000, consecutive stable synchronized cycles required to accept a level change (10 ms at 25 MHz); must be >= 1.
- LONG_COUNT, 25000000, cycles the debounced level must stay pressed before o_Long_Press fires (1 s at 25 MHz); must be >= 1.
- ACTIVE_HIGH, 1, 1: pin high means pressed; 0: pin low means pressed (input inverted after synchronizer).

Ports:
- i_Clock  input  1  system clock; single clock domain.
- i_Reset_n  input  1  asynchronous, active-low reset.
- i_Switch  input  1  raw asynchronous switch pin.
- o_Switch  output  1  debounced level, 1 = pressed.
- o_Press  output  1  one-cycle pulse on debounced 0->1.
- o_Release  output  1  one-cycle pulse on debounced 1->0.
- o_Long_Press  output  1  one-cycle pulse once per press after LONG_COUNT cycles held.

Behaviour:
- Reset (i_Reset_n=0, async assert): synchronizer flops load the released level. FSM goes to RELEASED, both counters clear to 0, all outputs 0. Reset mid-press discards the press with no release pulse. After deassert, a still-pressed switch is reported through the normal debounce path.
- Synchronizer: 2 flops on i_Switch, then polarity per ACTIVE_HIGH gives internal sample s (1 = pressed).
- FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - RELEASED: s=1 -> PRESS_PEND with debounce count=1.
  - PRESS_PEND: s=0 -> RELEASED, count cleared. s=1 and count==DEBOUNCE_COUNT -> PRESSED, o_Switch<=1, o_Press pulses this transition cycle. Otherwise count+1.
  - PRESSED: s=0 -> RELEASE_PEND with count=1.
  - RELEASE_PEND: mirror of PRESS_PEND; s=1 returns to PRESSED. Acceptance -> RELEASED, o_Switch<=0, o_Release pulses.
- Latency: a clean i_Switch edge reaches o_Switch and the pulse output 2+DEBOUNCE_COUNT clock edges later.
- Bounce: any sample reversion during a *_PEND state clears the debounce counter. The full DEBOUNCE_COUNT window restarts from the next qualifying sample.
- Pulses are registered, high for exactly 1 cycle, and coincide with the first cycle of the new o_Switch value.
- Hold counter:
  - Clears when entering PRESSED from PRESS_PEND; increments each cycle in PRESSED and RELEASE_PEND.
  - When it reaches LONG_COUNT: o_Long_Press pulses once and the counter saturates, so there is no repeat.
  - Clears on entry to RELEASED. A rejected release glitch (RELEASE_PEND -> PRESSED) does not clear it.
- A release after a long press still produces o_Release.
- Counter widths are $clog2(param+1). No arithmetic wrap is permitted; saturate instead.
- o_Press and o_Release are never high in the same cycle. o_Long_Press may coincide with neither.

Decomposition:
- Shared package/include switch_pkg:
  - 2-bit state encodings (RELEASED=0, PRESS_PEND=1, PRESSED=2, RELEASE_PEND=3).
  - Default timing constants for the 25 MHz board.
- One sub-module: sync_2ff (parameterized reset value, async active-low reset). It is reused by future pin inputs.

Test Plan:
(DEBOUNCE_COUNT=4, LONG_COUNT=20, ACTIVE_HIGH=1 unless stated)
- Reset with i_Switch=1 held: all outputs 0 during reset. o_Press and o_Switch rise exactly 6 edges after i_Reset_n deasserts.
- Clean press, i_Switch 0->1 held 40 cycles: o_Press single pulse 6 edges after the change, o_Switch=1. o_Long_Press single pulse 20 cycles after o_Press, with no repeat through cycle 40.
- Glitch, i_Switch high for 3 cycles then low: o_Switch stays 0 and no pulses occur. A following held press still needs the full 6 edges.
- Release bounce, from PRESSED toggle i_Switch every 2 cycles for 10 cycles then hold 0: exactly one o_Release, 6 edges after the last edge. The hold counter is not reset by rejected reversions.
- Reset mid-operation, assert i_Reset_n=0 for 2 cycles at 10 cycles into PRESSED: outputs drop to 0 asynchronously with no o_Release. With the switch still high, o_Press recurs 6 edges after deassert.
- ACTIVE_HIGH=0, i_Switch 1->0 held: o_Press after 6 edges. Returning to 1 gives o_Release after 6 edges.
